kernel_fetch_scheduler: RTL and testbench

Sequences AXI4 read bursts on one shared master read channel on behalf of three kernel FIFOs (kernel 0/1/2).
- Round-robin channel selection; a channel is skipped when disabled, finished, or its FIFO lacks space for a full burst.
- Per-channel address pointers walk start→end with optional wrap.
- Returned R beats are steered to the FIFO write port of the channel that owns the outstanding burst; one burst outstanding at a time.

---
 rtl/kernel_fetch_scheduler.sv | 179 +++++++++++++++++
 tb/tb_kernel_fetch_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_fetch_scheduler.sv
// Round-robin AXI4 read-burst sequencer feeding three kernel FIFOs from one master read channel.
// Define KFS_BURST_CHECK_EN to add the per-burst beat counter that drives burst_len_err.
module kernel_fetch_scheduler #(
    parameter int C_S_AXI_ID_WIDTH   = 3,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_BURST_LEN  = 8,
    parameter int C_ARID             = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [2:0]                    ch_en,
    input  logic [2:0]                    ch_wrap_en,
    input  logic [95:0]                   ch_start_addr,
    input  logic [95:0]                   ch_end_addr,
    input  logic [23:0]                   ch_fifo_free,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ch_wr_data,
    output logic [2:0]                    ch_wr_en,
    output logic                          busy,
    output logic                          done,
    output logic                          rresp_err,
    output logic                          burst_len_err,
    output logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_arid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
    output logic [7:0]                    M_axi_arlen,
    output logic [2:0]                    M_axi_arsize,
    output logic [1:0]                    M_axi_arburst,
    output logic                          M_axi_arvalid,
    input  logic                          M_axi_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
    input  logic [1:0]                    M_axi_rresp,
    input  logic                          M_axi_rlast,
    input  logic                          M_axi_rvalid,
    output logic                          M_axi_rready
);

    localparam int BPB = C_S_AXI_BURST_LEN * C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] start_a [3];
    logic [31:0] end_a   [3];
    logic [7:0]  free_a  [3];
    logic [31:0] ch_ptr  [3];
    logic [2:0]  active;
    logic [1:0]  rr, sel;
    logic        grant, run_over, ptr_fits;
    logic [32:0] nxt_addr;

    function automatic logic [1:0] rr_next(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            start_a[i] = ch_start_addr[i*32 +: 32];
            end_a[i]   = ch_end_addr[i*32 +: 32];
            free_a[i]  = ch_fifo_free[i*8 +: 8];
        end
    end

    assign run_over = stop || (active == 3'b000);
    assign grant    = active[rr] && (free_a[rr] >= 8'(C_S_AXI_BURST_LEN));
    // 33-bit sum so a pointer near the top of the map retires instead of wrapping to zero
    assign nxt_addr = {1'b0, ch_ptr[sel]} + 33'(BPB);
    assign ptr_fits = nxt_addr <= {1'b0, end_a[sel]};

    assign ch_wr_data    = M_axi_rdata;
    assign M_axi_arid    = C_S_AXI_ID_WIDTH'(C_ARID);
    assign M_axi_araddr  = C_S_AXI_ADDR_WIDTH'(ch_ptr[sel]);
    assign M_axi_arlen   = 8'(C_S_AXI_BURST_LEN - 1);
    assign M_axi_arsize  = 3'($clog2(C_S_AXI_DATA_WIDTH / 8));
    assign M_axi_arburst = 2'b01;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        M_axi_arvalid = 1'b0;
        M_axi_rready  = 1'b0;
        ch_wr_en      = 3'b000;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE:   if (start) state_nxt = SELECT;
            SELECT: begin
                if (run_over)   state_nxt = DONE;
                else if (grant) state_nxt = ADDR;
            end
            ADDR: begin
                M_axi_arvalid = 1'b1;
                if (M_axi_arready) state_nxt = DATA;
            end
            DATA: begin
                M_axi_rready = 1'b1;
                if (M_axi_rvalid) begin
                    ch_wr_en = 3'b001 << sel;
                    if (M_axi_rlast) state_nxt = SELECT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) ch_ptr[i] <= '0;
            active    <= 3'b000;
            rr        <= 2'd0;
            sel       <= 2'd0;
            rresp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < 3; i++) begin
                        ch_ptr[i] <= start_a[i];
                        active[i] <= ch_en[i] && (start_a[i] <= end_a[i]);
                    end
                    rr        <= 2'd0;
                    rresp_err <= 1'b0;
                end
                SELECT: if (!run_over) begin
                    if (grant) sel <= rr;
                    else       rr  <= rr_next(rr);
                end
                DATA: if (M_axi_rvalid) begin
                    if (M_axi_rresp != 2'b00) rresp_err <= 1'b1;
                    if (M_axi_rlast) begin
                        if (ptr_fits)             ch_ptr[sel] <= nxt_addr[31:0];
                        else if (ch_wrap_en[sel]) ch_ptr[sel] <= start_a[sel];
                        else                      active[sel] <= 1'b0;
                        rr <= rr_next(sel);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KFS_BURST_CHECK_EN
    localparam logic [7:0] LAST_BEAT = 8'(C_S_AXI_BURST_LEN - 1);
    logic [7:0] beat_cnt;

    // Flags an early rlast or a missing one; the FSM itself still leaves DATA only on rlast
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt      <= 8'd0;
            burst_len_err <= 1'b0;
        end else if (state == IDLE && start) begin
            burst_len_err <= 1'b0;
        end else if (state == ADDR) begin
            beat_cnt <= 8'd0;
        end else if (state == DATA && M_axi_rvalid) begin
            if (M_axi_rlast ? (beat_cnt != LAST_BEAT) : (beat_cnt >= LAST_BEAT))
                burst_len_err <= 1'b1;
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
        end
    end
`else
    assign burst_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_fetch_scheduler.sv
// Self-checking bench for kernel_fetch_scheduler: AXI read slave, burst scoreboard and
// a queue-based model of the round-robin address walk.
`timescale 1ns/1ps
module tb_kernel_fetch_scheduler;
    localparam int LEN = 8;
    localparam int BPB = 64;
`ifdef KFS_BURST_CHECK_EN
    localparam bit BL_EXP = 1'b1;
`else
    localparam bit BL_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [2:0]  ch_en, ch_wrap_en;
    logic [95:0] ch_start_addr, ch_end_addr;
    logic [23:0] ch_fifo_free;
    logic [63:0] ch_wr_data;
    logic [2:0]  ch_wr_en;
    logic        busy, done, rresp_err, burst_len_err;
    logic [2:0]  M_axi_arid;
    logic [31:0] M_axi_araddr;
    logic [7:0]  M_axi_arlen;
    logic [2:0]  M_axi_arsize;
    logic [1:0]  M_axi_arburst;
    logic        M_axi_arvalid, M_axi_arready;
    logic [63:0] M_axi_rdata;
    logic [1:0]  M_axi_rresp;
    logic        M_axi_rlast, M_axi_rvalid, M_axi_rready;

    always #5 clk = ~clk;

    kernel_fetch_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .ch_en(ch_en), .ch_wrap_en(ch_wrap_en),
        .ch_start_addr(ch_start_addr), .ch_end_addr(ch_end_addr),
        .ch_fifo_free(ch_fifo_free),
        .ch_wr_data(ch_wr_data), .ch_wr_en(ch_wr_en),
        .busy(busy), .done(done), .rresp_err(rresp_err), .burst_len_err(burst_len_err),
        .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
        .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst),
        .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready),
        .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp), .M_axi_rlast(M_axi_rlast),
        .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          ch;
    } burst_t;

    typedef struct {
        logic [2:0]  en;
        logic [95:0] s;
        logic [95:0] e;
        int          n_ar;
        int          n_beats;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    burst_t      exp_q[$];
    int          ar_cyc[$];
    int          arready_prob = 100, rvalid_prob = 100, ar_hold = 0, err_beat = -1, early_last = -1;
    int          cycle = 0, ar_count = 0, beat_count = 0, done_count = 0, start_cycle = 0;
    logic [31:0] first_addr = '0, last_addr = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference walk: each enabled channel yields start, start+BPB, ... while <= end,
    // and channels take turns 0,1,2,0,... skipping the ones already exhausted.
    function automatic void model_bursts(input logic [2:0] en, input logic [95:0] s, input logic [95:0] e);
        longint unsigned nxt[3];
        longint unsigned lim[3];
        bit              act[3];
        burst_t          b;
        for (int i = 0; i < 3; i++) begin
            nxt[i] = longint'(s[i*32 +: 32]);
            lim[i] = longint'(e[i*32 +: 32]);
            act[i] = en[i] && (nxt[i] <= lim[i]);
        end
        while (act[0] || act[1] || act[2]) begin
            for (int i = 0; i < 3; i++) begin
                if (act[i]) begin
                    b.addr = nxt[i][31:0];
                    b.ch   = i;
                    exp_q.push_back(b);
                    nxt[i] += BPB;
                    if (nxt[i] > lim[i]) act[i] = 0;
                end
            end
        end
    endfunction

    // AXI read slave plus scoreboard, driven just after each falling edge
    initial begin : slave
        bit          ar_hs, r_hs, bursting, waiting;
        int          owner, beat_idx, hold_left, wait_start;
        logic [31:0] held_addr;
        logic [2:0]  exp_en;
        burst_t      b;
        M_axi_arready = 1'b0;
        M_axi_rvalid  = 1'b0;
        M_axi_rlast   = 1'b0;
        M_axi_rresp   = 2'b00;
        M_axi_rdata   = '0;
        bursting = 0; waiting = 0; owner = -1; beat_idx = 0; hold_left = 0; wait_start = 0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!M_axi_arvalid) waiting = 0;
            else if (!waiting) begin
                waiting    = 1;
                hold_left  = ar_hold;
                held_addr  = M_axi_araddr;
                wait_start = cycle;
            end
            if (hold_left > 0) begin
                M_axi_arready = 1'b0;
                hold_left--;
            end else begin
                M_axi_arready = (int'($urandom_range(100, 1)) <= arready_prob);
            end
            M_axi_rdata = {$urandom, $urandom};
            if (bursting && int'($urandom_range(100, 1)) <= rvalid_prob) begin
                M_axi_rvalid = 1'b1;
                M_axi_rlast  = (beat_idx == LEN - 1) || (beat_idx == early_last);
                M_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            end else begin
                M_axi_rvalid = 1'b0;
                M_axi_rlast  = 1'b0;
                M_axi_rresp  = 2'b00;
            end
            #1;
            ar_hs = M_axi_arvalid && M_axi_arready;
            r_hs  = M_axi_rvalid && M_axi_rready;
            if (M_axi_arvalid) checkOutput("rready_during_addr", M_axi_rready, 0);
            if (M_axi_arvalid && waiting && cycle != wait_start)
                checkOutput("araddr_stable", M_axi_araddr, held_addr);
            if (ar_hs) begin
                checkOutput("ar_hold_respected", (cycle - wait_start) >= ar_hold, 1);
                checkOutput("arid", M_axi_arid, 1);
                checkOutput("arlen", M_axi_arlen, LEN - 1);
                checkOutput("arsize", M_axi_arsize, 3);
                checkOutput("arburst", M_axi_arburst, 1);
                checkOutput("ar_expected", exp_q.size() != 0, 1);
                owner = -1;
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    checkOutput("araddr_order", M_axi_araddr, b.addr);
                    owner = b.ch;
                end
                ar_count++;
                if (ar_count == 1) first_addr = M_axi_araddr;
                last_addr = M_axi_araddr;
                ar_cyc.push_back(cycle);
                bursting = 1;
                beat_idx = 0;
                waiting  = 0;
            end
            if (r_hs) begin
                exp_en = (owner >= 0) ? 3'(1 << owner) : 3'b000;
                checkOutput("wr_en_beat", ch_wr_en, exp_en);
                checkOutput("wr_data", ch_wr_data, M_axi_rdata);
                beat_count++;
                beat_idx++;
                if (M_axi_rlast) bursting = 0;
            end else begin
                checkOutput("wr_en_idle", ch_wr_en, 0);
            end
            if (done) done_count++;
            if (reset) begin
                bursting  = 0;
                waiting   = 0;
                hold_left = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] en, input logic [2:0] wrap, input logic [95:0] s,
                                 input logic [95:0] e, input logic [23:0] free);
        @(negedge clk);
        ch_en = en; ch_wrap_en = wrap; ch_start_addr = s; ch_end_addr = e; ch_fifo_free = free;
        ar_count = 0; beat_count = 0; first_addr = '0; last_addr = '0;
        ar_cyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        start_cycle = cycle;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0  = done_count;
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_count != d0) begin
                got = 1;
                break;
            end
        end
        checkOutput({name, "_done_seen"}, got, 1);
        if (got) begin
            checkOutput({name, "_busy_at_done"}, busy, 1);
            @(negedge clk);
            #2;
            checkOutput({name, "_done_one_cycle"}, done, 0);
            checkOutput({name, "_busy_after"}, busy, 0);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : test
        vec_t        vecs[6];
        logic [2:0]  en;
        logic [95:0] s, e;
        logic [31:0] sv, ev;
        int          n_exp, ok;

        vecs[0] = '{3'b111, {32'h3000, 32'h2000, 32'h1000}, {32'h3040, 32'h2040, 32'h1040}, 6, 48, 32'h1000, 32'h3040};
        vecs[1] = '{3'b010, {32'h0, 32'h500, 32'h0}, {32'h0, 32'h4FF, 32'h0}, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{3'b110, {32'h100, 32'h0, 32'h0}, {32'h1C0, 32'h0, 32'h0}, 5, 40, 32'h0, 32'h1C0};
        vecs[3] = '{3'b001, {32'h0, 32'h0, 32'hFFFFFFC0}, {32'h0, 32'h0, 32'hFFFFFFFF}, 1, 8, 32'hFFFFFFC0, 32'hFFFFFFC0};
        vecs[4] = '{3'b100, {32'h2000, 32'h0, 32'h0}, {32'h2030, 32'h0, 32'h0}, 1, 8, 32'h2000, 32'h2000};
        vecs[5] = '{3'b011, {32'h0, 32'h800, 32'h10}, {32'h0, 32'h880, 32'h10}, 4, 32, 32'h10, 32'h880};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        ch_en = '0; ch_wrap_en = '0; ch_start_addr = '0; ch_end_addr = '0; ch_fifo_free = '1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_arvalid", M_axi_arvalid, 0);
        checkOutput("rst_rready", M_axi_rready, 0);
        checkOutput("rst_wr_en", ch_wr_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rresp_err", rresp_err, 0);
        checkOutput("rst_burst_len_err", burst_len_err, 0);
        checkOutput("rst_araddr", M_axi_araddr, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] table-driven runs");
        for (int v = 0; v < 6; v++) begin
            model_bursts(vecs[v].en, vecs[v].s, vecs[v].e);
            applyStimulus(vecs[v].en, 3'b000, vecs[v].s, vecs[v].e, 24'hFFFFFF);
            wait_done(2000, "table");
            checkOutput("table_ar_count", ar_count, vecs[v].n_ar);
            checkOutput("table_beats", beat_count, vecs[v].n_beats);
            checkOutput("table_first_addr", first_addr, vecs[v].first);
            checkOutput("table_last_addr", last_addr, vecs[v].last);
            checkOutput("table_pending", exp_q.size(), 0);
            exp_q.delete();
        end

        $display("[TB] fifo-space gating");
        exp_q.push_back('{32'h3000, 2});
        exp_q.push_back('{32'h0000, 0});
        exp_q.push_back('{32'h0040, 0});
        applyStimulus(3'b101, 3'b000, {32'h3000, 32'h9000, 32'h0}, {32'h3000, 32'h9100, 32'h40},
                      {8'hFF, 8'hFF, 8'h04});
        repeat (20) @(negedge clk);
        ch_fifo_free[7:0] = 8'hFF;
        wait_done(2000, "space");
        checkOutput("space_ar_count", ar_count, 3);
        checkOutput("space_pending", exp_q.size(), 0);
        if (ar_cyc.size() >= 2) checkOutput("space_ch0_late", (ar_cyc[1] - start_cycle) >= 20, 1);
        else checkOutput("space_ch0_granted", ar_cyc.size(), 2);
        exp_q.delete();

        $display("[TB] wrap with stop");
        exp_q.push_back('{32'h0, 0});
        exp_q.push_back('{32'h40, 0});
        exp_q.push_back('{32'h0, 0});
        applyStimulus(3'b001, 3'b001, 96'h0, {64'h0, 32'h40}, 24'hFFFFFF);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #2;
            if (ar_count >= 3 && beat_count >= 2 * LEN + 2) begin
                ok = 1;
                break;
            end
        end
        checkOutput("wrap_third_burst_started", ok, 1);
        stop = 1'b1;
        wait_done(200, "wrap");
        stop = 1'b0;
        checkOutput("wrap_ar_count", ar_count, 3);
        checkOutput("wrap_beats", beat_count, 3 * LEN);
        checkOutput("wrap_pending", exp_q.size(), 0);
        exp_q.delete();

        $display("[TB] address backpressure");
        ar_hold = 10;
        model_bursts(3'b010, {32'h0, 32'h4000, 32'h0}, {32'h0, 32'h4040, 32'h0});
        applyStimulus(3'b010, 3'b000, {32'h0, 32'h4000, 32'h0}, {32'h0, 32'h4040, 32'h0}, 24'hFFFFFF);
        wait_done(500, "hold");
        ar_hold = 0;
        checkOutput("hold_ar_count", ar_count, 2);
        checkOutput("hold_beats", beat_count, 2 * LEN);
        exp_q.delete();

        $display("[TB] rresp error and mid-burst reset");
        err_beat = 3;
        model_bursts(3'b100, 96'h0, 96'h0);
        applyStimulus(3'b100, 3'b000, 96'h0, 96'h0, 24'hFFFFFF);
        wait_done(200, "rresp");
        checkOutput("rresp_beats", beat_count, LEN);
        checkOutput("rresp_err_sticky", rresp_err, 1);
        err_beat = -1;
        exp_q.delete();
        model_bursts(3'b001, {64'h0, 32'h100}, {64'h0, 32'h1C0});
        applyStimulus(3'b001, 3'b000, {64'h0, 32'h100}, {64'h0, 32'h1C0}, 24'hFFFFFF);
        checkOutput("rresp_err_cleared_by_start", rresp_err, 0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (beat_count >= LEN + 3) begin
                ok = 1;
                break;
            end
        end
        checkOutput("reset_mid_burst_reached", ok, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        checkOutput("midrst_arvalid", M_axi_arvalid, 0);
        checkOutput("midrst_rready", M_axi_rready, 0);
        checkOutput("midrst_wr_en", ch_wr_en, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_araddr", M_axi_araddr, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2;
        checkOutput("midrst_stays_idle", busy, 0);

        $display("[TB] early rlast");
        early_last = 4;
        model_bursts(3'b001, {64'h0, 32'h0}, {64'h0, 32'h40});
        applyStimulus(3'b001, 3'b000, {64'h0, 32'h0}, {64'h0, 32'h40}, 24'hFFFFFF);
        wait_done(200, "early");
        early_last = -1;
        checkOutput("early_ar_count", ar_count, 2);
        checkOutput("early_beats", beat_count, 10);
        checkOutput("early_burst_len_err", burst_len_err, BL_EXP);
        exp_q.delete();

        $display("[TB] randomized runs");
        for (int r = 0; r < 10; r++) begin
            en = 3'($urandom_range(7, 0));
            for (int i = 0; i < 3; i++) begin
                sv = 32'($urandom_range(1023, 0)) * 32'd16;
                if ($urandom_range(7, 0) == 0 && sv >= 32'd16) ev = sv - 32'd16;
                else ev = sv + 32'($urandom_range(6, 0)) * 32'd64 + 32'($urandom_range(63, 0));
                s[i*32 +: 32] = sv;
                e[i*32 +: 32] = ev;
            end
            arready_prob = int'($urandom_range(100, 20));
            rvalid_prob  = int'($urandom_range(100, 20));
            err_beat     = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            exp_q.delete();
            model_bursts(en, s, e);
            n_exp = exp_q.size();
            applyStimulus(en, 3'b000, s, e, 24'hFFFFFF);
            wait_done(4000, "rand");
            checkOutput("rand_ar_count", ar_count, n_exp);
            checkOutput("rand_beats", beat_count, n_exp * LEN);
            checkOutput("rand_pending", exp_q.size(), 0);
            checkOutput("rand_rresp_err", rresp_err, (err_beat >= 0) && (n_exp > 0));
            checkOutput("rand_burst_len_err", burst_len_err, 0);
        end
        arready_prob = 100;
        rvalid_prob  = 100;
        err_beat     = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
